// File: rtl/riscv_pkg.sv
// riscv_pkg
// Definitions shared across the core's fetch and execute stages:
//   XLEN             - datapath width
//   RESET_PC_DEFAULT - fetch PC after reset unless a top overrides it
//   pc_state_t       - states of the fetch PC controller
//   cmp_op_t         - branch comparator operations (BRANCH funct3 encodings)
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no request outstanding
        REQ   = 2'd1,   // request on the bus at pc
        DRAIN = 2'd2,   // redirect seen while a request was unacked
        TRAP  = 2'd3    // misaligned redirect taken; only reset leaves
    } pc_state_t;

    typedef enum logic [2:0] {
        CMP_EQ  = 3'b000,
        CMP_NE  = 3'b001,
        CMP_LT  = 3'b100,
        CMP_GE  = 3'b101,
        CMP_LTU = 3'b110,
        CMP_GEU = 3'b111
    } cmp_op_t;

endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc
// Combinational redirect decision and target computation for the EX stage.
// Ports:
//   b, br_en, jal_en, jalr_en - comparator result and control-flow decode flags
//   ex_pc, imm, rs1_d         - EX PC, sign-extended immediate, JALR base
//   redir                     - a control-flow change is required this cycle
//   target                    - redirect address (jalr > jal > br)
//   tgt_misaligned            - redir is set and target is not word aligned
module next_pc_calc #(
    parameter int XLEN = 32
) (
    input  logic            b,
    input  logic            br_en,
    input  logic            jal_en,
    input  logic            jalr_en,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_d,
    output logic            redir,
    output logic [XLEN-1:0] target,
    output logic            tgt_misaligned
);

    logic [XLEN-1:0] pc_rel_sum;
    logic [XLEN-1:0] reg_rel_sum;

    // Both sums wrap silently modulo 2^XLEN.
    assign pc_rel_sum  = ex_pc + imm;
    assign reg_rel_sum = rs1_d + imm;

    // NOTE: every output of a combinational block is assigned on every path
    // (here unconditionally); a missing assignment infers a latch.
    always_comb begin
        redir = jalr_en | jal_en | (br_en & b);
        // JAL and a taken branch share the PC-relative adder, so only JALR
        // needs to be singled out for priority.
        if (jalr_en) begin
            target = {reg_rel_sum[XLEN-1:1], 1'b0};
        end else begin
            target = pc_rel_sum;
        end
        tgt_misaligned = redir & (target[1:0] != 2'b00);
    end

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl
// Fetch-side program-counter controller. Owns the fetch PC, runs the
// instruction-memory request/ack handshake and squashes IF/ID on redirects.
// Ports:
//   clk, rst                    - clock; synchronous active-high reset
//   b, br_en, jal_en, jalr_en   - comparator result and EX decode flags
//   ex_pc, imm, rs1_d           - EX operands for the target adders
//   stall                       - hold the front end (no new request issued)
//   imem_req, imem_addr         - fetch request and address (addr == pc)
//   imem_ack                    - memory accepted the request / returned data
//   pc                          - current fetch PC
//   if_valid                    - this cycle's acked fetch is live
//   link                        - ex_pc + 4 for JAL/JALR rd write-back
//   flush                       - squash IF/ID this cycle
//   misalign                    - sticky misaligned-target flag
module pc_ctrl #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            b,
    input  logic            br_en,
    input  logic            jal_en,
    input  logic            jalr_en,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_d,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    output logic [XLEN-1:0] pc,
    output logic            if_valid,
    output logic [XLEN-1:0] link,
    output logic            flush,
    output logic            misalign
);

    import riscv_pkg::*;

    pc_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic            misalign_q, misalign_d;

    logic            redir;
    logic [XLEN-1:0] target;
    logic            tgt_misaligned;

    next_pc_calc #(
        .XLEN (XLEN)
    ) u_next_pc_calc (
        .b              (b),
        .br_en          (br_en),
        .jal_en         (jal_en),
        .jalr_en        (jalr_en),
        .ex_pc          (ex_pc),
        .imm            (imm),
        .rs1_d          (rs1_d),
        .redir          (redir),
        .target         (target),
        .tgt_misaligned (tgt_misaligned)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            tgt_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tgt_q      <= tgt_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        misalign_d = misalign_q;
        if_valid   = 1'b0;
        flush      = redir & (state_q != TRAP);

        // The flag is raised as soon as the bad target is seen; an
        // outstanding request still completes through DRAIN first.
        if (redir && tgt_misaligned && state_q != TRAP) begin
            misalign_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (redir) begin
                    pc_d = target;
                end
                if (redir && tgt_misaligned) begin
                    state_d = TRAP;
                end else if (!stall) begin
                    state_d = REQ;
                end
            end

            REQ: begin
                if (imem_ack) begin
                    if (redir) begin
                        pc_d = target;
                    end else begin
                        if_valid = 1'b1;
                        pc_d     = pc_q + XLEN'(4);
                    end
                    if (redir && tgt_misaligned) begin
                        state_d = TRAP;
                    end else if (stall) begin
                        state_d = IDLE;
                    end else begin
                        state_d = REQ;
                    end
                end else if (redir) begin
                    // Address must hold until the ack, so park the target.
                    tgt_d   = target;
                    state_d = DRAIN;
                end
            end

            DRAIN: begin
                if (redir) begin
                    tgt_d = target;
                end
                if (imem_ack) begin
                    // A redirect arriving with the ack is the latest one.
                    pc_d = redir ? target : tgt_q;
                    if (misalign_d) begin
                        state_d = TRAP;
                    end else if (stall) begin
                        state_d = IDLE;
                    end else begin
                        state_d = REQ;
                    end
                end
            end

            TRAP: begin
                state_d = TRAP;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_req  = (state_q == REQ) || (state_q == DRAIN);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign misalign  = misalign_q;
    assign link      = ex_pc + XLEN'(4);

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl
// Directed bench for pc_ctrl. Expected fetches (address, live/discard) are
// queued when the stimulus is set up and popped on each ack cycle.
module tb_pc_ctrl;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            b, br_en, jal_en, jalr_en;
    logic [XLEN-1:0] ex_pc, imm, rs1_d;
    logic            stall;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] pc;
    logic            if_valid;
    logic [XLEN-1:0] link;
    logic            flush;
    logic            misalign;

    typedef struct {
        string           tag;
        logic [XLEN-1:0] addr;
        logic            valid;
    } fetch_t;

    fetch_t exp_q[$];
    int     vec_cnt = 0;
    int     err_cnt = 0;

    pc_ctrl #(
        .XLEN     (XLEN),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .b         (b),
        .br_en     (br_en),
        .jal_en    (jal_en),
        .jalr_en   (jalr_en),
        .ex_pc     (ex_pc),
        .imm       (imm),
        .rs1_d     (rs1_d),
        .stall     (stall),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .pc        (pc),
        .if_valid  (if_valid),
        .link      (link),
        .flush     (flush),
        .misalign  (misalign)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check(input string tag, input logic [XLEN-1:0] obs,
                         input logic [XLEN-1:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_fetch(input string tag, input logic [XLEN-1:0] addr,
                              input logic valid);
        fetch_t e;
        e.tag   = tag;
        e.addr  = addr;
        e.valid = valid;
        exp_q.push_back(e);
    endtask

    // Called on a cycle where imem_ack is driven high during a request.
    task automatic fetch_check();
        fetch_t e;
        if (exp_q.size() == 0) begin
            vec_cnt++;
            err_cnt++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = exp_q.pop_front();
            check({e.tag, "_req"}, {31'b0, imem_req}, 32'd1);
            check({e.tag, "_addr"}, imem_addr, e.addr);
            check({e.tag, "_valid"}, {31'b0, if_valid}, {31'b0, e.valid});
        end
    endtask

    initial begin
        rst = 1'b1;
        b = 1'b0; br_en = 1'b0; jal_en = 1'b0; jalr_en = 1'b0;
        ex_pc = '0; imm = '0; rs1_d = '0;
        stall = 1'b0; imem_ack = 1'b0;

        // Reset state
        tick(); tick(); settle();
        check("rst_pc",       pc,                 32'h0);
        check("rst_req",      {31'b0, imem_req},  32'd0);
        check("rst_if_valid", {31'b0, if_valid},  32'd0);
        check("rst_misalign", {31'b0, misalign},  32'd0);
        check("rst_flush",    {31'b0, flush},     32'd0);

        // First fetch on the 2nd cycle after reset falls
        rst = 1'b0;
        settle();
        check("first_idle_req", {31'b0, imem_req}, 32'd0);
        tick(); settle();
        check("first_req", {31'b0, imem_req}, 32'd1);

        // Zero-wait stream: 0, 4, 8, 12
        for (int i = 0; i < 4; i++) push_fetch("stream", XLEN'(i * 4), 1'b1);
        imem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            fetch_check();
            tick();
        end

        // Taken branch during REQ with ack: 0x40 - 8 = 0x38
        ex_pc = 32'h40; imm = 32'hFFFF_FFF8; br_en = 1'b1; b = 1'b1;
        push_fetch("br_taken", 32'h10, 1'b0);
        settle();
        check("br_taken_flush", {31'b0, flush}, 32'd1);
        check("br_link", link, 32'h44);
        fetch_check();
        tick();
        br_en = 1'b0; b = 1'b0;
        push_fetch("br_target", 32'h38, 1'b1);
        settle();
        fetch_check();
        tick();

        // Not-taken branch: no flush, sequential advance
        br_en = 1'b1; b = 1'b0;
        push_fetch("br_not_taken", 32'h3C, 1'b1);
        settle();
        check("br_nt_flush", {31'b0, flush}, 32'd0);
        fetch_check();
        tick();
        br_en = 1'b0; imem_ack = 1'b0;
        settle();
        check("br_nt_next", imem_addr, 32'h40);

        // JALR while the request stays unacked for 3 cycles
        jalr_en = 1'b1; rs1_d = 32'h101; imm = 32'h4; ex_pc = 32'h80;
        settle();
        check("jalr_flush", {31'b0, flush}, 32'd1);
        check("jalr_link", link, 32'h84);
        check("jalr_hold0", imem_addr, 32'h40);
        tick();
        jalr_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            check("drain_req", {31'b0, imem_req}, 32'd1);
            check("drain_addr", imem_addr, 32'h40);
            tick();
        end
        imem_ack = 1'b1;
        push_fetch("drain_ack", 32'h40, 1'b0);
        settle();
        fetch_check();
        tick();
        imem_ack = 1'b0;
        settle();
        check("jalr_target", imem_addr, 32'h104);
        check("jalr_target_req", {31'b0, imem_req}, 32'd1);

        // Stall during an outstanding request
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            check("stall_hold_req", {31'b0, imem_req}, 32'd1);
            tick();
        end
        imem_ack = 1'b1;
        push_fetch("stall_ack", 32'h104, 1'b1);
        settle();
        fetch_check();
        tick();
        imem_ack = 1'b0;
        settle();
        check("stall_idle_req", {31'b0, imem_req}, 32'd0);
        tick();
        stall = 1'b0;
        settle();
        check("stall_fall_req", {31'b0, imem_req}, 32'd0);
        tick(); settle();
        check("stall_resume_req", {31'b0, imem_req}, 32'd1);
        check("stall_resume_addr", imem_addr, 32'h108);

        // Latest target wins in DRAIN
        jal_en = 1'b1; ex_pc = 32'h200; imm = 32'h10;
        tick();
        ex_pc = 32'h300; imm = 32'h0;
        settle();
        check("drain_redir_flush", {31'b0, flush}, 32'd1);
        tick();
        jal_en = 1'b0; imem_ack = 1'b1;
        push_fetch("latest_ack", 32'h108, 1'b0);
        settle();
        fetch_check();
        tick();
        push_fetch("latest_target", 32'h300, 1'b1);
        settle();
        fetch_check();
        tick();
        imem_ack = 1'b0;

        // Misaligned JAL in REQ with ack: straight to TRAP
        imem_ack = 1'b1;
        jal_en = 1'b1; ex_pc = 32'h10; imm = 32'h2;
        push_fetch("mis_ack", 32'h304, 1'b0);
        settle();
        fetch_check();
        tick();
        imem_ack = 1'b0;
        settle();
        check("trap_misalign", {31'b0, misalign}, 32'd1);
        check("trap_pc", pc, 32'h12);
        for (int i = 0; i < 3; i++) begin
            ex_pc = XLEN'(32'h1000 + i * 16); imm = 32'h0;
            imem_ack = i[0];
            settle();
            check("trap_req", {31'b0, imem_req}, 32'd0);
            check("trap_flush", {31'b0, flush}, 32'd0);
            tick();
        end
        jal_en = 1'b0; imem_ack = 1'b0;

        // Reset out of TRAP
        rst = 1'b1;
        tick(); settle();
        check("trap_rst_pc", pc, 32'h0);
        check("trap_rst_misalign", {31'b0, misalign}, 32'd0);
        rst = 1'b0;
        tick(); settle();
        check("post_rst_req", {31'b0, imem_req}, 32'd1);

        // Misaligned target while a request is outstanding: DRAIN then TRAP
        jal_en = 1'b1; ex_pc = 32'h20; imm = 32'h1;
        settle();
        check("mis_drain_flush", {31'b0, flush}, 32'd1);
        tick();
        jal_en = 1'b0;
        settle();
        check("mis_drain_flag", {31'b0, misalign}, 32'd1);
        imem_ack = 1'b1;
        push_fetch("mis_drain_ack", 32'h0, 1'b0);
        settle();
        fetch_check();
        tick();
        imem_ack = 1'b0;
        settle();
        check("mis_drain_trap_req", {31'b0, imem_req}, 32'd0);
        check("mis_drain_trap_pc", pc, 32'h21);

        check("sb_empty", XLEN'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Fetch-side program-counter controller for the RISC-V core. It consumes the branch comparator's taken bit `b`, together with the jump/branch decode flags and operands from EX, and computes the redirect target. It owns the fetch PC and drives the instruction-memory request/ack handshake, emitting a one-cycle squash to the front end on every redirect.

## Interface
- `XLEN`, 32: datapath width.
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `b` in 1: comparator result; 1 = branch condition true.
- `br_en` in 1: EX holds a conditional branch.
- `jal_en` in 1: EX holds JAL.
- `jalr_en` in 1: EX holds JALR.
- `ex_pc` in XLEN: PC of the EX instruction.
- `imm` in XLEN: sign-extended immediate.
- `rs1_d` in XLEN: rs1 operand (JALR base).
- `stall` in 1: hold the front end; inhibits issuing a new request.
- `imem_req` out 1: fetch request.
- `imem_addr` out XLEN: fetch address, equal to `pc`.
- `imem_ack` in 1: memory accepted the request and returned data this cycle.
- `pc` out XLEN: current fetch PC.
- `if_valid` out 1: this cycle's acked fetch is live; 0 means discard it.
- `link` out XLEN: `ex_pc + 4`, combinational, written to rd by JAL/JALR.
- `flush` out 1: squash IF/ID, combinational, same cycle as the redirect.
- `misalign` out 1: sticky, set when a redirect target has `target[1:0] != 0`.

## Operation
- Redirect is `redir = jalr_en | jal_en | (br_en & b)`. Priority is jalr > jal > br.
- Targets:
  - br/jal: `ex_pc + imm`.
  - jalr: `(rs1_d + imm) & ~1`.
  - All sums are modulo 2^XLEN; wrap-around is silent.
- `flush = redir & (state != TRAP)`.
- States:
  - IDLE: req=0. If `redir`, then `pc <= target`. Go to REQ if `!stall`, else stay in IDLE.
  - REQ: req=1, addr=pc.
    - ack & !redir: `if_valid=1`, `pc <= pc+4`.
    - ack & redir: `if_valid=0`, `pc <= target`.
    - After either ack case: next is IDLE if `stall`, else REQ.
    - !ack & redir: `tgt_q <= target`, go to DRAIN.
    - !ack & !redir: stay in REQ. `stall` is ignored while the request is outstanding.
  - DRAIN: req=1 with the old address.
    - Each further redir overwrites `tgt_q`; the latest target wins.
    - On ack: `if_valid=0`, `pc <= tgt_q`, next is IDLE if `stall`, else REQ.
  - TRAP: req=0, `flush=0`. All inputs except `rst` are ignored. Exit only by reset.
- Handshake rules:
  - `imem_req` never drops, and `imem_addr` never changes, while a request is unacked.
  - `imem_ack` while req=0 is ignored.
- Misaligned target:
  - `misalign <= 1` and `pc <= target` (kept for debug).
  - No request is issued to that target.
  - If a request is outstanding, finish via DRAIN, then enter TRAP instead of REQ/IDLE.
  - Otherwise enter TRAP directly.
- Reset mid-operation: `rst` wins over everything, including an outstanding request; the request is abandoned.

## Timing
- Reset values: `pc=RESET_PC`, `imem_req=0`, `if_valid=0`, `misalign=0`, `flush=0`, state IDLE, `tgt_q=0`.
- First fetch: `imem_req=1` on the 2nd cycle after `rst` falls, provided `stall=0`.
- Throughput: with zero-wait memory (ack in the same cycle as req), one fetch per cycle; `pc` advances by 4 each cycle.
- Redirect latency:
  - In IDLE, or in REQ with ack: the target is fetched the next cycle.
  - In REQ without ack: the target is fetched the cycle after the old request's ack.
- `if_valid`, `flush` and `link` are combinational. `pc` and `misalign` are registered.

## Structure
- Shared `riscv_pkg`:
  - `XLEN`.
  - Default `RESET_PC`.
  - `pc_state_t` enum {IDLE, REQ, DRAIN, TRAP}.
  - `cmp_op` encodings, shared with the comparator.
- Sub-module `next_pc_calc` (combinational): handles priority, target adders, `& ~1`, and the alignment check. It outputs `redir`, `target` and `tgt_misaligned`.
- `pc_ctrl` holds the FSM, `pc`, `tgt_q` and `misalign`.

## Test plan
- Reset then ack every cycle, no redirects → `pc` reads 0, 4, 8, 12 on consecutive cycles; `if_valid=1` on each ack.
- `ex_pc=0x40`, `imm=-8`, `br_en=1`, `b=1` during REQ with ack → `flush=1` and `if_valid=0` that cycle; next `imem_addr=0x38`. Same stimulus with `b=0` → no flush, `pc=pc+4`.
- `jalr_en=1`, `rs1_d=0x101`, `imm=4`, while a request is unacked for 3 cycles → `imem_addr` stays at the old PC through DRAIN; ack gives `if_valid=0`; next address is 0x104; `link=ex_pc+4`.
- `stall=1` during an outstanding request, ack arrives after 2 cycles → req held until ack, then req=0 while stall holds; req returns the cycle after stall falls.
- `jal_en=1`, `ex_pc=0x10`, `imm=2` → `misalign=1`, state TRAP, `imem_req` stays 0 and `flush` stays 0 for all further redirects until `rst`; `rst` restores `pc=RESET_PC` and `misalign=0`.
